// File: rtl/ntr_cmd_sequencer_if.sv
// Command/response and ROM fetch signals between the NTR command capture, the
// sequencer and the ROM backing store.
interface ntr_cmd_sequencer_if;
    logic        cs1;
    logic        cmd_valid;
    logic [63:0] command;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic        busy;
    logic        underrun;
    logic        cmd_err;

    modport slave (
        input  cs1, cmd_valid, command, rom_ack, rom_data,
        output dout, dout_valid, rom_req, rom_addr, busy, underrun, cmd_err
    );

    modport master (
        output cs1, cmd_valid, command, rom_ack, rom_data,
        input  dout, dout_valid, rom_req, rom_addr, busy, underrun, cmd_err
    );
endinterface

// File: rtl/ntr_cmd_sequencer.sv
// NTR cartridge response sequencer: decodes a captured command, waits a fixed
// latency, then streams bytes from ROM (via a prefetch FIFO), constants or chip ID.
module ntr_cmd_sequencer #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          LATENCY    = 8,
    parameter logic [31:0] CHIP_ID    = 32'h0000_3FC2,
    parameter logic [13:0] DUMMY_LEN  = 14'h2000,
    parameter logic [13:0] BLOCK_LEN  = 14'h0200
) (
    input  logic                  clk,
    input  logic                  rst,
    ntr_cmd_sequencer_if.slave    bus
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FDEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] WLAST  = 16'(LATENCY - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    localparam logic [1:0] M_ROM   = 2'd0;
    localparam logic [1:0] M_DUMMY = 2'd1;
    localparam logic [1:0] M_ID    = 2'd2;
    localparam logic [1:0] M_UNK   = 2'd3;

    logic [2:0]    state, state_n;
    logic [1:0]    mode;
    logic [13:0]   len, remaining, fetched, fetched_n;
    logic [1:0]    id_idx;
    logic [15:0]   wait_cnt;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fcnt, fcnt_n;
    logic [1:0]    dec_mode;
    logic [13:0]   dec_len;
    logic [31:0]   dec_addr;
    logic [7:0]    tx_byte;
    logic          accept, active, consume, ack, push, pop, flush, rom_req_n;

    always_comb begin
        dec_mode = M_UNK;
        dec_len  = 14'd0;
        dec_addr = 32'd0;
        case (bus.command[7:0])
            8'h9F: begin dec_mode = M_DUMMY; dec_len = DUMMY_LEN; end
            8'h00: begin dec_mode = M_ROM;   dec_len = BLOCK_LEN; end
            8'hB7: begin
                dec_mode = M_ROM;
                dec_len  = BLOCK_LEN;
                // address bytes arrive most-significant first
                dec_addr = {bus.command[15:8], bus.command[23:16],
                            bus.command[31:24], bus.command[39:32]};
            end
            8'h90, 8'hB8: begin dec_mode = M_ID; dec_len = 14'd4; end
            default: ;
        endcase
    end

    assign accept  = (state == S_IDLE) && bus.cmd_valid;
    assign active  = (state == S_WAIT) || (state == S_SEND);
    assign consume = (state == S_SEND) && !bus.cs1;
    assign ack     = bus.rom_req && bus.rom_ack;
    assign push    = ack && active && !bus.cs1;
    assign pop     = consume && (mode == M_ROM) && (fcnt != '0);
    assign flush   = accept || (active && bus.cs1) || ((state == S_DONE) && bus.cs1);
    assign fcnt_n  = flush ? '0 : fcnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign fetched_n = fetched + {13'd0, ack};

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.cmd_valid) state_n = S_WAIT;
            S_WAIT: begin
                if (bus.cs1)                state_n = (bus.rom_req && !bus.rom_ack) ? S_ABORT : S_IDLE;
                else if (wait_cnt == WLAST) state_n = S_SEND;
            end
            S_SEND: begin
                if (bus.cs1)                state_n = (bus.rom_req && !bus.rom_ack) ? S_ABORT : S_IDLE;
                else if (mode != M_UNK && remaining == 14'd1) state_n = S_DONE;
            end
            // a fetch still in flight after the last byte is drained through ABORT
            S_DONE:  if (bus.cs1) state_n = (bus.rom_req && !bus.rom_ack) ? S_ABORT : S_IDLE;
            S_ABORT: if (bus.rom_ack) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // one request in flight; a new one only if the FIFO has room for its byte
    assign rom_req_n = (bus.rom_req && !bus.rom_ack)
                    || (accept && dec_mode == M_ROM && dec_len != 14'd0)
                    || (active && (state_n == S_WAIT || state_n == S_SEND)
                        && mode == M_ROM && fetched_n < len && fcnt_n < FDEPTH);

    always_comb begin
        tx_byte = 8'hFF;
        case (mode)
            M_ROM:   if (fcnt != '0) tx_byte = fifo_mem[rd_ptr];
            M_ID:    tx_byte = CHIP_ID[{id_idx, 3'b000} +: 8];
            default: tx_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.rom_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            mode           <= M_UNK;
            len            <= '0;
            remaining      <= '0;
            fetched        <= '0;
            id_idx         <= '0;
            wait_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fcnt           <= '0;
            bus.rom_req    <= 1'b0;
            bus.rom_addr   <= '0;
            bus.dout       <= 8'hFF;
            bus.dout_valid <= 1'b0;
            bus.underrun   <= 1'b0;
            bus.cmd_err    <= 1'b0;
        end else begin
            state       <= state_n;
            fcnt        <= fcnt_n;
            bus.rom_req <= rom_req_n;
            if (accept) begin
                mode         <= dec_mode;
                len          <= dec_len;
                remaining    <= dec_len;
                fetched      <= '0;
                id_idx       <= '0;
                wait_cnt     <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                bus.underrun <= 1'b0;
                bus.cmd_err  <= (dec_mode == M_UNK);
                if (dec_mode == M_ROM) bus.rom_addr <= dec_addr;
            end else begin
                if (ack) begin
                    fetched      <= fetched_n;
                    bus.rom_addr <= bus.rom_addr + 32'd1;
                end
                if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
                if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + AW'(1);
                    if (pop)  rd_ptr <= rd_ptr + AW'(1);
                end
                if (consume) begin
                    remaining <= remaining - 14'd1;
                    id_idx    <= id_idx + 2'd1;
                    if (mode == M_ROM && fcnt == '0) bus.underrun <= 1'b1;
                end
            end
            bus.dout       <= consume ? tx_byte : 8'hFF;
            bus.dout_valid <= consume;
        end
    end

    assign bus.busy = (state != S_IDLE);
endmodule

// File: tb/tb_ntr_cmd_sequencer.sv
// Directed bench for ntr_cmd_sequencer with a ROM responder model and a
// byte collector sampling dout on the falling edge.
module tb_ntr_cmd_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntr_cmd_sequencer_if bus();

    ntr_cmd_sequencer #(.FIFO_DEPTH(4), .LATENCY(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_dly = 0;
    int          n_ack = 0;
    logic [31:0] lo_addr, hi_addr;
    logic [7:0]  q[$];

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [63:0] c);
        bus.command   = c;
        bus.cmd_valid = 1'b1;
        bus.cs1       = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input int bound, input string tag);
        for (int i = 0; i < bound && q.size() < n; i++) tick();
        chk(tag, q.size(), n);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        for (int i = 0; i < bound && bus.busy; i++) tick();
        chk(tag, bus.busy, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dout"},   bus.dout, 8'hFF);
        chk({tag, "_dvld"},   bus.dout_valid, 1'b0);
        chk({tag, "_rreq"},   bus.rom_req, 1'b0);
        chk({tag, "_raddr"},  bus.rom_addr, 32'h0);
        chk({tag, "_busy"},   bus.busy, 1'b0);
        chk({tag, "_undr"},   bus.underrun, 1'b0);
        chk({tag, "_cerr"},   bus.cmd_err, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.dout_valid === 1'b1) q.push_back(bus.dout);
    end

    // ROM model: acknowledges a request after ack_dly waiting cycles
    initial begin
        int wcnt;
        wcnt = 0;
        bus.rom_ack  = 1'b0;
        bus.rom_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.rom_ack = 1'b0;
            if (rst || bus.rom_req !== 1'b1) wcnt = 0;
            else if (wcnt >= ack_dly) begin
                bus.rom_ack  = 1'b1;
                bus.rom_data = rom_byte(bus.rom_addr);
                n_ack++;
                if (bus.rom_addr < lo_addr) lo_addr = bus.rom_addr;
                if (bus.rom_addr > hi_addr) hi_addr = bus.rom_addr;
                wcnt = 0;
            end else wcnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, k;
        rst = 1'b1;
        bus.cs1 = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.command = 64'h0;
        lo_addr = '1;
        hi_addr = '0;
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // chip ID: bytes appear 10 cycles after cmd_valid
        q.delete();
        send_cmd(64'h90);
        chk("id_busy", bus.busy, 1'b1);
        repeat (8) tick();
        chk("id_early", bus.dout_valid, 1'b0);
        tick(); chk("id_v0", bus.dout_valid, 1'b1); chk("id_b0", bus.dout, 8'hC2);
        tick(); chk("id_b1", bus.dout, 8'h3F);
        tick(); chk("id_b2", bus.dout, 8'h00);
        tick(); chk("id_b3", bus.dout, 8'h00); chk("id_v3", bus.dout_valid, 1'b1);
        tick(); chk("id_done_v", bus.dout_valid, 1'b0); chk("id_done_d", bus.dout, 8'hFF);
        chk("id_done_busy", bus.busy, 1'b1);
        bus.cs1 = 1'b1;
        tick();
        chk("id_idle", bus.busy, 1'b0); chk("id_idle_d", bus.dout, 8'hFF);

        // B7 block read from 0x1000 with single-cycle ack
        n_ack = 0; lo_addr = '1; hi_addr = '0; ack_dly = 0;
        q.delete();
        send_cmd(64'h0000_0000_1000_00B7);
        chk("b7_req", bus.rom_req, 1'b1);
        chk("b7_addr", bus.rom_addr, 32'h1000);
        wait_q(512, 1000, "b7_count");
        bad = 0;
        foreach (q[i]) if (q[i] !== rom_byte(32'h1000 + i)) bad++;
        chk("b7_data", bad, 0);
        chk("b7_undr", bus.underrun, 1'b0);
        chk("b7_nack", n_ack, 512);
        chk("b7_lo", lo_addr, 32'h1000);
        chk("b7_hi", hi_addr, 32'h11FF);
        repeat (3) tick();
        chk("b7_done", bus.busy, 1'b1);
        chk("b7_noreq", bus.rom_req, 1'b0);
        bus.cs1 = 1'b1;
        wait_idle(20, "b7_idle");

        // block read from 0 with slow ROM: underruns fill with FF
        ack_dly = 20;
        q.delete();
        send_cmd(64'h00);
        wait_q(512, 2000, "slow_count");
        chk("slow_undr", bus.underrun, 1'b1);
        chk("slow_first", q[0], 8'hFF);
        bad = 0; k = 0;
        foreach (q[i]) if (q[i] != 8'hFF) begin
            if (q[i] !== rom_byte(k)) bad++;
            k++;
        end
        chk("slow_data", bad, 0);
        chk("slow_some", k > 0, 1'b1);
        bus.cs1 = 1'b1;
        wait_idle(100, "slow_idle");

        // abort with a request pending: ABORT holds until the ack
        ack_dly = 10; n_ack = 0;
        q.delete();
        send_cmd(64'h0000_0000_2000_00B7);
        chk("ab_undr_clr", bus.underrun, 1'b0);
        chk("ab_req", bus.rom_req, 1'b1);
        bus.cs1 = 1'b1;
        tick();
        chk("ab_busy", bus.busy, 1'b1);
        chk("ab_hold", bus.rom_req, 1'b1);
        chk("ab_addr", bus.rom_addr, 32'h2000);
        wait_idle(50, "ab_idle");
        chk("ab_req_off", bus.rom_req, 1'b0);
        chk("ab_nack", n_ack, 1);
        chk("ab_nodata", q.size(), 0);

        // dummy read aborted after 100 bytes, then a normal ID read
        q.delete();
        send_cmd(64'h9F);
        repeat (108) tick();
        bus.cs1 = 1'b1;
        tick();
        chk("dm_idle", bus.busy, 1'b0);
        chk("dm_req", bus.rom_req, 1'b0);
        chk("dm_count", q.size(), 100);
        bad = 0;
        foreach (q[i]) if (q[i] !== 8'hFF) bad++;
        chk("dm_data", bad, 0);
        q.delete();
        send_cmd(64'hB8);
        repeat (13) tick();
        chk("id2_count", q.size(), 4);
        chk("id2_data", {q[3], q[2], q[1], q[0]}, 32'h0000_3FC2);
        bus.cs1 = 1'b1;
        tick();
        chk("id2_idle", bus.busy, 1'b0);

        // unknown opcode, ignored cmd_valid, async reset mid-SEND
        send_cmd(64'h3C);
        chk("unk_err", bus.cmd_err, 1'b1);
        repeat (9) tick();
        chk("unk_v", bus.dout_valid, 1'b1);
        chk("unk_d", bus.dout, 8'hFF);
        bus.command = 64'h90;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("unk_ign_err", bus.cmd_err, 1'b1);
        repeat (20) tick();
        chk("unk_busy", bus.busy, 1'b1);
        chk("unk_v2", bus.dout_valid, 1'b1);
        chk("unk_d2", bus.dout, 8'hFF);
        rst = 1'b1;
        #1;
        chk_reset("arst");
        tick();
        rst = 1'b0;
        bus.cs1 = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
